// File: rtl/ov_frame_reader.sv
// rtl/ov_frame_reader.sv - OV7670 + AL422B frame capture/readout engine feeding a pixel write FIFO
// Optional VSYNC watchdog is built when OV_TIMEOUT_EN is defined.
module ov_frame_reader #(
  parameter int H_ACT       = 320,
  parameter int V_ACT       = 240,
  parameter int BPP         = 2,
  parameter int UW          = 9,
  parameter int AFULL       = 500,
  parameter int RST_CYC     = 6,
  parameter int WAIT_CYC    = 80000,
  parameter int TIMEOUT_CYC = 4000000
) (
  input  logic          S_CLK,
  input  logic          RST,
  input  logic          init_done,
  output logic          start_init,
  input  logic          cap_en,
  input  logic          cap_req,
  input  logic [7:0]    OV_data,
  input  logic          OV_vsync,
  output logic          OV_wrst,
  output logic          OV_rrst,
  output logic          OV_wen,
  output logic          OV_oe,
  output logic          OV_rclk,
  input  logic [UW-1:0] w_usedw,
  output logic          w_req,
  output logic [15:0]   w_data,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          busy,
  output logic          err_timeout
);

  localparam int NPIX = H_ACT * V_ACT;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int WW   = $clog2(WAIT_CYC + 1);
  localparam int RW   = $clog2(RST_CYC + 1);
  localparam logic [UW-1:0] AFULL_W = UW'(AFULL);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WRST = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_RRST = 3'd4;
  localparam logic [2:0] S_READ = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]    state;
  logic          vs_s1, vs_s2, vs_prev, vs_rise;
  logic          pend, init_sent;
  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] rst_cnt;
  logic [PW-1:0] pix_cnt;
  logic          rd_ph, byte_idx;
  logic [7:0]    hi_byte;
  logic          stall, wd_fire;

  assign vs_rise = vs_s2 & ~vs_prev;
  assign OV_oe   = 1'b0;
  assign busy    = (state == S_WRST) || (state == S_CAPT) || (state == S_RRST) || (state == S_READ);
  // Only a pixel that has not started may be held back, so bytes stay aligned.
  assign stall   = !byte_idx && (w_usedw >= AFULL_W);

`ifdef OV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_run;

  assign wd_run  = ((state == S_IDLE) && (cap_en || pend)) || (state == S_CAPT);
  assign wd_fire = wd_run && !vs_rise && (wd_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge S_CLK) begin
    if (RST || !wd_run || vs_rise || wd_fire) wd_cnt <= '0;
    else                                      wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge S_CLK) begin
    if (RST)          err_timeout <= 1'b0;
    else if (wd_fire) err_timeout <= 1'b1;
    else if (cap_req) err_timeout <= 1'b0;
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state      <= S_INIT;
      wait_cnt   <= '0;
      init_sent  <= 1'b0;
      rst_cnt    <= '0;
      pix_cnt    <= '0;
      rd_ph      <= 1'b0;
      byte_idx   <= 1'b0;
      hi_byte    <= '0;
      pend       <= 1'b0;
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_prev    <= 1'b0;
      start_init <= 1'b0;
      OV_wrst    <= 1'b1;
      OV_rrst    <= 1'b1;
      OV_wen     <= 1'b0;
      OV_rclk    <= 1'b0;
      w_req      <= 1'b0;
      w_data     <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vs_s1      <= OV_vsync;
      vs_s2      <= vs_s1;
      vs_prev    <= vs_s2;
      start_init <= 1'b0;
      w_req      <= 1'b0;
      frame_done <= 1'b0;

      if (wd_fire) begin
        state   <= S_IDLE;
        OV_wen  <= 1'b0;
        OV_wrst <= 1'b1;
        pend    <= 1'b0;
      end else begin
        case (state)
          S_INIT: begin
            if (!init_sent) begin
              if (wait_cnt == WW'(WAIT_CYC - 1)) begin
                start_init <= 1'b1;
                init_sent  <= 1'b1;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end else if (init_done) begin
              state <= S_IDLE;
            end
          end
          S_IDLE: begin
            if ((cap_en || pend) && vs_rise) begin
              state   <= S_WRST;
              OV_wrst <= 1'b0;
              rst_cnt <= '0;
              pend    <= 1'b0;
            end
          end
          S_WRST: begin
            if (rst_cnt == RW'(RST_CYC - 1)) begin
              OV_wrst <= 1'b1;
              OV_wen  <= 1'b1;
              state   <= S_CAPT;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_CAPT: begin
            if (vs_rise) begin
              OV_wen  <= 1'b0;
              OV_rrst <= 1'b0;
              OV_rclk <= 1'b0;
              rst_cnt <= '0;
              state   <= S_RRST;
            end
          end
          S_RRST: begin
            // One read-clock period per count; release on a falling edge.
            OV_rclk <= ~OV_rclk;
            if (OV_rclk) begin
              if (rst_cnt == RW'(RST_CYC - 1)) begin
                OV_rrst  <= 1'b1;
                pix_cnt  <= '0;
                rd_ph    <= 1'b0;
                byte_idx <= 1'b0;
                state    <= S_READ;
              end else begin
                rst_cnt <= rst_cnt + 1'b1;
              end
            end
          end
          S_READ: begin
            if (pix_cnt == PW'(NPIX)) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end else if (!rd_ph) begin
              if (!stall) begin
                OV_rclk <= 1'b1;
                rd_ph   <= 1'b1;
              end
            end else begin
              OV_rclk <= 1'b0;
              rd_ph   <= 1'b0;
              if ((BPP == 2) && !byte_idx) begin
                hi_byte  <= OV_data;
                byte_idx <= 1'b1;
              end else begin
                byte_idx <= 1'b0;
                w_req    <= 1'b1;
                pix_cnt  <= pix_cnt + 1'b1;
                w_data   <= (BPP == 2) ? {hi_byte, OV_data} : {8'h00, OV_data};
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_INIT;
        endcase
      end

      if (cap_req) pend <= 1'b1;
    end
  end

endmodule

// File: doc/ov_frame_reader.md
# ov_frame_reader

Parametrised camera-to-FIFO frame engine for OV7670-class sensors with an AL422B-style frame buffer. Handles power-up wait and the init handshake, write-reset and capture of one frame on VSYNC, read-reset and readout, and packing of sensor bytes into pixels for the downstream write FIFO. Supports any frame size, 1 or 2 bytes per pixel, and single-shot or continuous capture. Stalls cleanly on FIFO almost-full, only at pixel boundaries, so bytes never misalign. Sits between the SCCB init block and the UART/display FIFO.

## Interface
- H_ACT, 320: active pixels per line.
- V_ACT, 240: active lines per frame.
- BPP, 2: bytes per pixel, 1 or 2.
- UW, 9: width of `w_usedw`.
- AFULL, 500: stall threshold on `w_usedw`.
- RST_CYC, 6: cycles `OV_wrst` / `OV_rrst` are held low.
- WAIT_CYC, 80000: power-up wait, in S_CLK cycles.
- TIMEOUT_CYC, 4000000: VSYNC watchdog, in cycles. Used only with OV_TIMEOUT_EN.
- S_CLK  in  1  sole clock.
- RST  in  1  synchronous, active-high reset.
- init_done  in  1  sensor register init complete.
- start_init  out  1  one-cycle pulse requesting sensor init.
- cap_en  in  1  continuous capture while high.
- cap_req  in  1  one-cycle single-shot capture request.
- OV_data  in  8  buffer read data.
- OV_vsync  in  1  sensor VSYNC, asynchronous.
- OV_wrst, OV_rrst  out  1  buffer write/read pointer reset, active low.
- OV_wen  out  1  buffer write enable.
- OV_oe  out  1  constant 0.
- OV_rclk  out  1  registered buffer read clock.
- w_usedw  in  UW  downstream FIFO fill level.
- w_req  out  1  one-cycle write strobe.
- w_data  out  16  pixel. BPP=1 uses [7:0]; [15:8] is 0.
- frame_done  out  1  one-cycle pulse after the last pixel.
- frame_cnt  out  16  completed frames, wraps at 65535→0.
- busy  out  1  high in WRST, CAPT, RRST, READ.
- err_timeout  out  1  sticky watchdog error.

## Operation
- Reset values: start_init 0, OV_wrst 1, OV_rrst 1, OV_wen 0, OV_rclk 0, w_req 0, w_data 0, frame_done 0, frame_cnt 0, busy 0, err_timeout 0. State goes to INIT and the wait counter clears.
- VSYNC passes through a 2-flop synchroniser. `vs_rise` is asserted when the sync output is 1 and its previous value was 0.
- A `pend` flag is set by cap_req in any state. It is cleared on entry to WRST.
- FSM:
  - INIT: count WAIT_CYC. At terminal count, pulse start_init once, then wait for init_done and go to IDLE.
  - IDLE: when (cap_en|pend) is true and `vs_rise` occurs, go to WRST. Otherwise stay in IDLE.
  - WRST: OV_wrst=0 for RST_CYC cycles, then go to CAPT.
  - CAPT: OV_wen=1. On `vs_rise`, set OV_wen=0 and go to RRST. `vs_rise` during WRST is ignored.
  - RRST: OV_rrst=0 for RST_CYC read-clock periods with OV_rclk toggling, then go to READ.
  - READ: read H_ACT*V_ACT pixels, then go to DONE.
  - DONE: 1 cycle. Pulse frame_done, increment frame_cnt, go to IDLE.
- Byte read: 2 cycles per byte. Cycle A sets OV_rclk=1. Cycle B sets OV_rclk=0 and samples OV_data.
- Packing: with BPP=2, the first byte goes to [15:8] and the second to [7:0]. w_req asserts in the cycle after the final byte is sampled, with w_data valid in that same cycle.
- Stall: checked only before the first byte of a pixel. If w_usedw >= AFULL, OV_rclk stays 0 and no byte is read. Resume when w_usedw < AFULL. A started pixel always completes.
- Pixel counter width is clog2(H_ACT*V_ACT+1). Comparison is exact equality with H_ACT*V_ACT.
- cap_en falling mid-frame: the current frame completes, then the FSM idles.
- cap_req while busy: latched in `pend` and serviced after DONE.

## Timing
- IDLE→WRST occurs 3 cycles after the OV_vsync rising edge: 2 synchroniser cycles plus 1 state-register cycle.
- Per-pixel throughput without stall is 2*BPP+? Exactly: 2*BPP cycles. The back-to-back w_req spacing is 2*BPP cycles.
- DONE follows the last w_req by 1 cycle. IDLE follows DONE by 1 cycle.
- RST asserted in any state takes effect at the next edge and aborts the frame. No frame_done is issued. frame_cnt returns to 0.

## Configuration
- OV_TIMEOUT_EN defined:
  - A watchdog counter runs in IDLE while armed and in CAPT.
  - If it reaches TIMEOUT_CYC without `vs_rise`, then: err_timeout is set, OV_wen=0, OV_wrst=1, `pend` clears, and the FSM goes to IDLE.
  - err_timeout clears on cap_req or RST.
- OV_TIMEOUT_EN undefined: no counter is built, err_timeout is tied to 0, and the FSM waits indefinitely.

## Test plan
- Reset and init, with WAIT_CYC=100:
  - Hold RST 5 cycles: all outputs at reset values.
  - After release, start_init pulses exactly once, 100 cycles later.
  - init_done=1 → IDLE.
- Single shot, H_ACT=4, V_ACT=2, BPP=2, buffer model returning bytes 0x00,0x01,...:
  - Send cap_req and two VSYNC pulses.
  - Expect 8 w_req with w_data 0x0001, 0x0203 … 0x0E0F, one frame_done, frame_cnt=1.
- Stall: same frame; force w_usedw=AFULL after pixel 2 for 50 cycles.
  - No OV_rclk edges while stalled.
  - Output sequence still 0x0001 … 0x0E0F with no gaps or shifts.
- BPP=1, continuous: cap_en=1 for 3 VSYNC periods of frames.
  - Expect 8 w_req per frame with [15:8]=0, and frame_cnt counting 1,2,3.
  - Drop cap_en mid-third frame: the frame still completes.
- Mid-operation reset: assert RST in READ after pixel 3.
  - No frame_done.
  - State returns to INIT, outputs take reset values, frame_cnt=0.
- Watchdog (OV_TIMEOUT_EN, TIMEOUT_CYC=1000): cap_req with no VSYNC.
  - err_timeout=1 at cycle 1000+.
  - A fresh cap_req clears it.
